redun_sq_sequencer: RTL and testbench
=====================================

# redun_sq_sequencer

Host-side iteration controller that drives the `redun_wrapper` squaring interface in its single clock domain. It accepts a start value and an iteration count T, issues one square at a time through `o_start`/`o_sq`, and feeds each `i_valid`/`i_sq` result back in as the next operand. After T squares it returns the final value, or an error code on timeout, lock loss or abort. It sits between the host/shell command logic and the wrapper, in the `i_clk` domain.

## Interface
- `ITER_W`, 64: width of the iteration count and the completed-iteration counter.
- `TIMEOUT_CYC`, 4096: maximum cycles from `o_start` to `i_valid` before a timeout error is raised.
- `i_clk` in 1: clock, the same as the wrapper's `i_clk`.
- `i_rst_n` in 1: reset, asynchronous and active-low.
- `i_cmd_val` in 1: command valid.
- `o_cmd_rdy` out 1: command ready.
- `i_cmd_sq` in `redun0_t`: start value.
- `i_cmd_iter` in `ITER_W`: number of squarings T.
- `i_abort` in 1: cancels the command in flight.
- `o_start` out 1: one-cycle issue strobe to the wrapper's `i_start`.
- `o_sq` out `redun0_t`: operand to the wrapper's `i_sq_in`.
- `i_valid` in 1: wrapper `o_valid`.
- `i_sq` in `redun0_t`: wrapper `o_sq_out`.
- `i_locked` in 1: wrapper `o_locked`.
- `o_res_val` out 1: result valid.
- `i_res_rdy` in 1: result ready.
- `o_res` out `redun0_t`: final or last captured value.
- `o_res_err` out 2: error code. 0 = ok, 1 = timeout, 2 = lock lost, 3 = abort.
- `o_iter_done` out `ITER_W`: squarings completed.
- `o_stray` out 1: sticky flag set by `i_valid` arriving outside WAIT_RES.

## Operation
- **States:** IDLE, WAIT_LOCK, ISSUE, WAIT_RES, DONE, ERROR.
- **IDLE**
  - `o_cmd_rdy` = 1.
  - On `i_cmd_val`: latch `cur` ← `i_cmd_sq` and `rem` ← `i_cmd_iter`.
  - Clear `o_iter_done`, `o_stray` and the error code.
  - If `i_cmd_iter` == 0, go to DONE with `o_res` = `i_cmd_sq`. Otherwise go to WAIT_LOCK.
- **WAIT_LOCK:** stay until `i_locked` = 1, then go to ISSUE. There is no timeout here.
- **ISSUE**
  - `o_start` = 1 for exactly this cycle, with `o_sq` = `cur`.
  - Clear the watchdog, then go to WAIT_RES.
- **WAIT_RES**, evaluated in priority order:
  1. `i_abort` → ERROR with code 3.
  2. `i_locked` = 0 → ERROR with code 2.
  3. `i_valid` → `cur` ← `i_sq`, `rem` ← `rem` − 1, `o_iter_done` ← +1. Go to DONE if `rem` was 1, else go to ISSUE.
  4. Watchdog reaches `TIMEOUT_CYC` − 1 → ERROR with code 1.
  5. Otherwise increment the watchdog.
- **`i_abort` in WAIT_LOCK or ISSUE:** go to ERROR with code 3. In ISSUE, `o_start` is still emitted that cycle.
- **`i_abort` in IDLE, DONE or ERROR:** ignored.
- **DONE / ERROR**
  - `o_res_val` = 1, `o_res` = `cur`, `o_res_err` = code.
  - All three hold stable until `i_res_rdy`, then go to IDLE.
- **`o_stray`:** `i_valid` in any state other than WAIT_RES sets `o_stray`; the data is discarded. `o_stray` clears only on command accept.
- **Registers:** `o_sq` is driven from the `cur` register at all times.
- **Widths:**
  - `rem` and `o_iter_done` are `ITER_W` bits; neither can wrap, since `rem` ≤ `i_cmd_iter`.
  - The watchdog is `$clog2(TIMEOUT_CYC)` bits.

## Timing
- **Reset values:** all outputs 0, state IDLE, `cur` = 0, `rem` = 0. `o_cmd_rdy` rises the first cycle after `i_rst_n` deasserts.
- **Mid-operation reset:** asserting reset at any point returns to IDLE immediately. No result is presented.
- **Command accept:** on the edge where `i_cmd_val` && `o_cmd_rdy`. `o_cmd_rdy` falls the following cycle.
- **First issue:** with `i_locked` already high, `o_start` asserts 2 cycles after the accept edge (WAIT_LOCK, then ISSUE).
- **Loop:** `o_start` for iteration n+1 asserts the cycle after `i_valid` for iteration n. One iteration therefore takes wrapper latency + 1 cycles.
- **Final result:** `o_res_val` asserts the cycle after the final `i_valid`.
- **Result handshake:** the transfer happens on the edge where `o_res_val` && `i_res_rdy`. `o_cmd_rdy` rises the next cycle, so back-to-back commands have one IDLE cycle between them.
- **Outstanding operations:** exactly one square is outstanding at any time. `o_start` never asserts while in WAIT_RES.

## Structure
- **Shared package:** `redun0_t` and `NUM_WRDS` come from `redun_mont_pkg`. Add to that package:
  - `redun_err_t`, a 2-bit enum: ERR_NONE, ERR_TIMEOUT, ERR_LOCK, ERR_ABORT.
  - `redun_seq_state_t`, the state enum.
- **Sub-modules:** none are required. The watchdog is an inline counter.
- **Integration:** a top-level instantiates this block alongside `redun_wrapper`, connected port to port.

## Test plan
- **Normal run:** start 3, T = 4, wrapper model replying with a square 10 cycles after `o_start` → `o_res` = 43046721, `o_res_err` = 0, `o_iter_done` = 4, four `o_start` pulses exactly 11 cycles apart.
- **T = 0:** start value 7 → DONE 1 cycle after accept, `o_res` = 7, zero `o_start` pulses.
- **Timeout:** model drops the 2nd reply → ERROR with code 1 `TIMEOUT_CYC` cycles after the 2nd `o_start`, `o_iter_done` = 1, `o_res` = first square.
- **Lock:** `i_locked` low at accept → no `o_start` until lock rises. Dropping lock in WAIT_RES → code 2.
- **Abort and stray:** `i_abort` during WAIT_RES of iteration 3 → code 3, `o_iter_done` = 2. An `i_valid` pulse while in IDLE → `o_stray` = 1, cleared on the next accept.
- **Reset and handshake:** async reset asserted mid-WAIT_RES → all outputs 0 immediately. Hold `i_res_rdy` low 5 cycles → `o_res` stays stable throughout.

Source files
------------

// File: rtl/redun_sq_sequencer_pkg.sv
// redun_sq_sequencer_pkg: operand type, error codes and sequencer state encoding shared by the squaring sequencer
package redun_sq_sequencer_pkg;
    localparam int NUM_WRDS = 4;
    localparam int WRD_W    = 32;
    typedef logic [NUM_WRDS*WRD_W-1:0] redun0_t;
    typedef enum logic [1:0] {ERR_NONE, ERR_TIMEOUT, ERR_LOCK, ERR_ABORT} redun_err_t;
    typedef enum logic [2:0] {ST_IDLE, ST_WAIT_LOCK, ST_ISSUE, ST_WAIT_RES, ST_DONE, ST_ERROR} redun_seq_state_t;
endpackage

// File: rtl/redun_sq_sequencer_if.sv
// redun_sq_sequencer_if: command, wrapper-squaring and result signals; master = sequencer side, slave = host/wrapper side
interface redun_sq_sequencer_if #(
    parameter int ITER_W = 64
) ();
    import redun_sq_sequencer_pkg::*;
    logic              i_cmd_val;
    logic              o_cmd_rdy;
    redun0_t           i_cmd_sq;
    logic [ITER_W-1:0] i_cmd_iter;
    logic              i_abort;
    logic              o_start;
    redun0_t           o_sq;
    logic              i_valid;
    redun0_t           i_sq;
    logic              i_locked;
    logic              o_res_val;
    logic              i_res_rdy;
    redun0_t           o_res;
    redun_err_t        o_res_err;
    logic [ITER_W-1:0] o_iter_done;
    logic              o_stray;
    modport master (
        input  i_cmd_val, i_cmd_sq, i_cmd_iter, i_abort, i_valid, i_sq, i_locked, i_res_rdy,
        output o_cmd_rdy, o_start, o_sq, o_res_val, o_res, o_res_err, o_iter_done, o_stray
    );
    modport slave (
        output i_cmd_val, i_cmd_sq, i_cmd_iter, i_abort, i_valid, i_sq, i_locked, i_res_rdy,
        input  o_cmd_rdy, o_start, o_sq, o_res_val, o_res, o_res_err, o_iter_done, o_stray
    );
endinterface

// File: rtl/redun_sq_sequencer.sv
// redun_sq_sequencer: iterated-squaring controller; ports i_clk, i_rst_n (async active-low), bus (command in, square issue/return, result out)
module redun_sq_sequencer
    import redun_sq_sequencer_pkg::*;
#(
    parameter int ITER_W      = 64,
    parameter int TIMEOUT_CYC = 4096
) (
    input logic                  i_clk,
    input logic                  i_rst_n,
    redun_sq_sequencer_if.master bus
);
    localparam int WD_W = $clog2(TIMEOUT_CYC);
    redun_seq_state_t  state, nxt;
    redun_err_t        err_nxt;
    redun0_t           cur, cur_nxt;
    logic [ITER_W-1:0] rem;
    logic [WD_W-1:0]   wd;
    logic              accept, adv, tmo, fin;
    assign accept  = state == ST_IDLE && bus.o_cmd_rdy && bus.i_cmd_val;
    assign adv     = state == ST_WAIT_RES && bus.i_valid && !bus.i_abort && bus.i_locked;
    assign tmo     = wd == WD_W'(TIMEOUT_CYC - 1);
    assign cur_nxt = accept ? bus.i_cmd_sq : adv ? bus.i_sq : cur;
    assign fin     = nxt == ST_DONE || nxt == ST_ERROR;
    assign err_nxt = bus.i_abort ? ERR_ABORT : !bus.i_locked ? ERR_LOCK : ERR_TIMEOUT;
    assign bus.o_sq = cur;
    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:      nxt = !accept ? ST_IDLE : bus.i_cmd_iter == '0 ? ST_DONE : ST_WAIT_LOCK;
            ST_WAIT_LOCK: nxt = bus.i_abort ? ST_ERROR : bus.i_locked ? ST_ISSUE : ST_WAIT_LOCK;
            ST_ISSUE:     nxt = bus.i_abort ? ST_ERROR : ST_WAIT_RES;
            ST_WAIT_RES:  nxt = adv ? (rem == ITER_W'(1) ? ST_DONE : ST_ISSUE)
                              : bus.i_abort || !bus.i_locked || tmo ? ST_ERROR : ST_WAIT_RES;
            default:      nxt = bus.i_res_rdy ? ST_IDLE : state;
        endcase
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= ST_IDLE;
            cur             <= '0;
            rem             <= '0;
            wd              <= '0;
            bus.o_cmd_rdy   <= 1'b0;
            bus.o_start     <= 1'b0;
            bus.o_res_val   <= 1'b0;
            bus.o_res       <= '0;
            bus.o_res_err   <= ERR_NONE;
            bus.o_iter_done <= '0;
            bus.o_stray     <= 1'b0;
        end else begin
            state           <= nxt;
            cur             <= cur_nxt;
            rem             <= accept ? bus.i_cmd_iter : adv ? rem - ITER_W'(1) : rem;
            wd              <= state == ST_WAIT_RES ? wd + WD_W'(1) : '0;
            bus.o_cmd_rdy   <= nxt == ST_IDLE;
            bus.o_start     <= nxt == ST_ISSUE;
            bus.o_res_val   <= fin;
            bus.o_res       <= fin ? cur_nxt : bus.o_res;
            bus.o_res_err   <= accept ? ERR_NONE : nxt == ST_ERROR && state != ST_ERROR ? err_nxt : bus.o_res_err;
            bus.o_iter_done <= accept ? '0 : adv ? bus.o_iter_done + ITER_W'(1) : bus.o_iter_done;
            bus.o_stray     <= (bus.o_stray && !accept) || (bus.i_valid && state != ST_WAIT_RES);
        end
    end
endmodule

// File: tb/tb_redun_sq_sequencer.sv
// tb_redun_sq_sequencer: scoreboard bench with a squaring-wrapper model for redun_sq_sequencer
module tb_redun_sq_sequencer;
    import redun_sq_sequencer_pkg::*;
    localparam int TO = 4096;
    typedef struct {
        redun0_t     res;
        redun_err_t  err;
        logic [63:0] it;
    } exp_t;
    logic    clk;
    logic    rst_n;
    int      n_chk;
    int      n_fail;
    int      cyc;
    int      acc_cyc;
    int      lat;
    int      drop_k;
    int      mdl_cnt;
    int      rc;
    int      lk;
    bit      stray_req;
    redun0_t mdl_op;
    exp_t    mon_e;
    exp_t    exp_q[$];
    int      start_q[$];
    redun_sq_sequencer_if #(.ITER_W(64)) bus ();
    redun_sq_sequencer #(.ITER_W(64), .TIMEOUT_CYC(TO)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp_v);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk_all_zero(input string tag);
        chk({tag, "_cmd_rdy"}, 128'(bus.o_cmd_rdy), 0);
        chk({tag, "_start"}, 128'(bus.o_start), 0);
        chk({tag, "_res_val"}, 128'(bus.o_res_val), 0);
        chk({tag, "_res"}, bus.o_res, 0);
        chk({tag, "_res_err"}, 128'(bus.o_res_err), 0);
        chk({tag, "_iter_done"}, 128'(bus.o_iter_done), 0);
        chk({tag, "_stray"}, 128'(bus.o_stray), 0);
        chk({tag, "_sq"}, bus.o_sq, 0);
    endtask
    task automatic send(input redun0_t sq, input logic [63:0] it, input bit push,
                        input redun0_t er, input redun_err_t ee, input logic [63:0] ei);
        int k = 0;
        if (push) exp_q.push_back(exp_t'{res: er, err: ee, it: ei});
        start_q.delete();
        bus.i_cmd_sq   = sq;
        bus.i_cmd_iter = it;
        bus.i_cmd_val  = 1'b1;
        @(negedge clk);
        while (!bus.o_cmd_rdy && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("cmd_accept", 128'(bus.o_cmd_rdy), 1);
        acc_cyc = cyc;
        tick();
        bus.i_cmd_val = 1'b0;
    endtask
    task automatic wait_res(output int c);
        int k = 0;
        @(negedge clk);
        while (!bus.o_res_val && k < 6000) begin
            @(negedge clk);
            k++;
        end
        chk("res_val_seen", 128'(bus.o_res_val), 1);
        c = cyc;
    endtask
    task automatic wait_starts(input int n);
        int k = 0;
        @(negedge clk);
        while (start_q.size() < n && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("start_count_reached", 128'(start_q.size()), 128'(n));
    endtask
    initial begin
        mdl_cnt     = 0;
        mdl_op      = '0;
        bus.i_valid = 1'b0;
        bus.i_sq    = '0;
        forever begin
            @(negedge clk);
            bus.i_valid = stray_req;
            if (mdl_cnt > 0) begin
                mdl_cnt--;
                if (mdl_cnt == 0) begin
                    bus.i_valid = 1'b1;
                    bus.i_sq    = mdl_op * mdl_op;
                end
            end
            if (bus.o_start) begin
                start_q.push_back(cyc);
                if (start_q.size() != drop_k) begin
                    mdl_op  = bus.o_sq;
                    mdl_cnt = lat;
                end
            end
        end
    end
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.o_res_val && bus.i_res_rdy) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_result: got o_res 0x%0h err %0d, expected no result", bus.o_res, bus.o_res_err);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("res_value", bus.o_res, mon_e.res);
                    chk("res_err", 128'(bus.o_res_err), 128'(mon_e.err));
                    chk("res_iter_done", 128'(bus.o_iter_done), 128'(mon_e.it));
                end
            end
        end
    end
    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL global_timeout: got no end of test, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "global timeout");
    end
    initial begin
        n_chk          = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        lat            = 10;
        drop_k         = 0;
        stray_req      = 1'b0;
        bus.i_cmd_val  = 1'b0;
        bus.i_cmd_sq   = '0;
        bus.i_cmd_iter = '0;
        bus.i_abort    = 1'b0;
        bus.i_locked   = 1'b1;
        bus.i_res_rdy  = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("cmd_rdy_before_edge", 128'(bus.o_cmd_rdy), 0);
        @(negedge clk);
        chk("cmd_rdy_after_reset", 128'(bus.o_cmd_rdy), 1);
        tick();
        send(3, 4, 1'b1, 128'd43046721, ERR_NONE, 4);
        wait_res(rc);
        chk("normal_starts", 128'(start_q.size()), 4);
        chk("normal_first_start", 128'(start_q[0]), 128'(acc_cyc + 2));
        for (int i = 0; i < 3; i++) chk("normal_start_gap", 128'(start_q[i+1] - start_q[i]), 11);
        chk("normal_res_latency", 128'(rc - start_q[3]), 11);
        tick();
        send(7, 0, 1'b1, 7, ERR_NONE, 0);
        wait_res(rc);
        chk("t0_latency", 128'(rc - acc_cyc), 1);
        chk("t0_starts", 128'(start_q.size()), 0);
        tick();
        stray_req = 1'b1;
        tick();
        stray_req = 1'b0;
        @(negedge clk);
        chk("stray_set_idle", 128'(bus.o_stray), 1);
        tick();
        send(2, 1, 1'b1, 4, ERR_NONE, 1);
        @(negedge clk);
        chk("stray_clear_accept", 128'(bus.o_stray), 0);
        wait_res(rc);
        tick();
        drop_k = 2;
        send(5, 3, 1'b1, 25, ERR_TIMEOUT, 1);
        wait_res(rc);
        chk("timeout_starts", 128'(start_q.size()), 2);
        chk("timeout_latency", 128'(rc - start_q[1]), 128'(TO + 1));
        drop_k = 0;
        tick();
        bus.i_locked = 1'b0;
        send(2, 2, 1'b1, 16, ERR_NONE, 2);
        repeat (6) @(negedge clk);
        chk("nolock_no_start", 128'(start_q.size()), 0);
        tick();
        bus.i_locked = 1'b1;
        lk = cyc;
        wait_res(rc);
        chk("lock_rise_start", 128'(start_q[0]), 128'(lk + 1));
        tick();
        send(3, 3, 1'b1, 9, ERR_LOCK, 1);
        wait_starts(2);
        tick();
        bus.i_locked = 1'b0;
        wait_res(rc);
        tick();
        bus.i_locked = 1'b1;
        repeat (12) tick();
        send(3, 5, 1'b1, 81, ERR_ABORT, 2);
        wait_starts(3);
        tick();
        tick();
        bus.i_abort = 1'b1;
        tick();
        bus.i_abort = 1'b0;
        wait_res(rc);
        repeat (12) tick();
        @(negedge clk);
        chk("stray_late_reply", 128'(bus.o_stray), 1);
        tick();
        bus.i_res_rdy = 1'b0;
        send(3, 1, 1'b1, 9, ERR_NONE, 1);
        wait_res(rc);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_res_val", 128'(bus.o_res_val), 1);
            chk("stall_res", bus.o_res, 9);
            chk("stall_err", 128'(bus.o_res_err), 0);
        end
        tick();
        bus.i_res_rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post_hs_cmd_rdy", 128'(bus.o_cmd_rdy), 1);
        chk("post_hs_res_val", 128'(bus.o_res_val), 0);
        tick();
        send(3, 4, 1'b0, 0, ERR_NONE, 0);
        wait_starts(2);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        repeat (12) tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("midreset_no_result", 128'(bus.o_res_val), 0);
        @(negedge clk);
        chk("midreset_cmd_rdy", 128'(bus.o_cmd_rdy), 1);
        tick();
        send(4, 1, 1'b1, 16, ERR_NONE, 1);
        wait_res(rc);
        tick();
        tick();
        chk("scoreboard_empty", 128'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
